// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the fetch/data RAM arbiter: FSM encoding,
// default timeout, latched-access record and the response-data helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_MEM = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int WAIT_CNT_W      = 8;

    // One RAM access as seen by the shared RAM port.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } access_t;

    localparam access_t ACCESS_NONE = '0;

    function automatic logic [WAIT_CNT_W-1:0] last_wait_cycle(input int timeout);
        return WAIT_CNT_W'(timeout - 1);
    endfunction

    // An aborted access returns zero; a completed read returns the RAM word.
    function automatic logic [31:0] resp_data(input logic aborted, input logic [31:0] dout);
        return aborted ? 32'h0 : dout;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and the MEM
// stage; data accesses win ties, one access in flight, timeout aborts a hung RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_ready,
    output logic        bus_err
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = last_wait_cycle(TIMEOUT);

    arb_state_t            state;
    arb_state_t            state_next;
    access_t               lat;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  dropped;

    logic mem_elig;
    logic if_elig;
    logic grant_mem;
    logic grant_if;
    logic own_req;
    logic timeout_hit;
    logic done;
    logic deliver;

    // A port whose ack is showing this cycle has already been served; its req
    // is still the old request, so it must not be granted again.
    assign mem_elig  = mem_req & ~mem_ack;
    assign if_elig   = if_req & ~if_ack;
    assign grant_mem = (state == IDLE) & mem_elig;
    assign grant_if  = (state == IDLE) & ~mem_elig & if_elig;

    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    assign ram_addr  = lat.addr;
    assign ram_din   = lat.wdata;

    assign timeout_hit = ram_cs & ~ram_ready & (wait_cnt == LAST_WAIT);
    assign done        = ram_cs & (ram_ready | timeout_hit);
    assign deliver     = done & own_req & ~dropped;

    // NOTE: state is held in flops written only with <=, so every reader
    // sees the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (mem_elig) begin
                    state_next = WAIT_MEM;
                end else if (if_elig) begin
                    state_next = WAIT_IF;
                end
            end
            WAIT_IF, WAIT_MEM: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        own_req = 1'b0;
        unique case (state)
            WAIT_IF: begin
                ram_cs  = 1'b1;
                own_req = if_req;
            end
            WAIT_MEM: begin
                ram_cs  = 1'b1;
                ram_we  = lat.we;
                own_req = mem_req;
            end
            default: begin
                ram_cs  = 1'b0;
                ram_we  = 1'b0;
                own_req = 1'b0;
            end
        endcase
    end

    // Operands are captured at grant so the RAM port stays stable even if the
    // requester changes its inputs after losing interest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat <= ACCESS_NONE;
        end else if (grant_mem) begin
            lat <= '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        end else if (grant_if) begin
            lat <= '{we: 1'b0, addr: if_addr, wdata: 32'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!ram_cs) begin
            wait_cnt <= '0;
        end else if (!ram_ready && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Once the owner drops its request the access still runs to completion on
    // the RAM, but nothing is reported back even if the request reappears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped <= 1'b0;
        end else if (!ram_cs) begin
            dropped <= 1'b0;
        end else if (!own_req) begin
            dropped <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ack  <= deliver & (state == WAIT_IF);
            mem_ack <= deliver & (state == WAIT_MEM);
            bus_err <= deliver & timeout_hit;
            if (deliver && (state == WAIT_IF)) begin
                if_rdata <= resp_data(timeout_hit, ram_dout);
            end
            // Completed writes keep the last load value visible.
            if (deliver && (state == WAIT_MEM) && (timeout_hit || !lat.we)) begin
                mem_rdata <= resp_data(timeout_hit, ram_dout);
            end
        end
    end

    a_ack_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(if_ack && mem_ack));
    a_err_with_ack : assert property (@(posedge clk) disable iff (!rst_n)
        bus_err |-> (if_ack || mem_ack));
    a_fetch_never_writes : assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT_IF) |-> !ram_we);

endmodule
